nibble_deserializer: RTL and testbench

Serial-to-parallel front end for the 4-bit load register. Accepts a qualified serial bit stream, assembles WIDTH-bit words in a private shift register, then presents each completed word on `D` with a one-cycle `L` strobe. `D` and `L` wire directly to the register's `D` and `L` inputs. `D` stays stable between strobes, so the register captures a clean word.

---
 rtl/nibble_deser_pkg.sv | 16 +
 rtl/nibble_deserializer_sipo.sv | 42 ++++
 rtl/nibble_deserializer.sv | 131 +++++++++++++
 tb/tb_nibble_deserializer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/nibble_deser_pkg.sv
// Shared types and helpers for the nibble deserializer.
package nibble_deser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        PARITY = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 4;

    function automatic int cnt_width(input int w);
        return (w < 1) ? 1 : $clog2(w + 1);
    endfunction

endpackage

// File: rtl/nibble_deserializer_sipo.sv
// Serial-in/parallel-out shift register with selectable bit order.
module sipo_shift
    import nibble_deser_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_en,
    input  logic             i_clr,
    input  logic             i_bit,
    output logic [WIDTH-1:0] o_word
);

    logic [WIDTH-1:0] r_word;
    logic [WIDTH-1:0] w_shift;

    generate
        if (WIDTH == 1) begin : g_one
            assign w_shift = i_bit;
        end else if (MSB_FIRST != 0) begin : g_msb
            assign w_shift = {r_word[WIDTH-2:0], i_bit};
        end else begin : g_lsb
            assign w_shift = {i_bit, r_word[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_word <= '0;
        end else if (i_clr) begin
            r_word <= '0;
        end else if (i_en) begin
            r_word <= w_shift;
        end
    end

    // Look-ahead: includes the bit being accepted this cycle
    assign o_word = i_en ? w_shift : r_word;

endmodule

// File: rtl/nibble_deserializer.sv
// Serial-to-parallel front end for the load register.
// Optional trailing even-parity check: NIBBLE_DESER_PARITY_EN.
module nibble_deserializer
    import nibble_deser_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MSB_FIRST = 1
) (
    input  logic             CLK,
    input  logic             R_N,
    input  logic             SIN,
    input  logic             SVALID,
    input  logic             CLR,
    output logic [WIDTH-1:0] D,
    output logic             L,
    output logic             BUSY,
    output logic             ERR
);

    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef NIBBLE_DESER_PARITY_EN
    localparam logic [CW-1:0] FULL = CW'(WIDTH);
`endif

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CW-1:0]    r_cnt;
    logic [CW-1:0]    w_cnt_nxt;
    logic [WIDTH-1:0] r_d;
    logic [WIDTH-1:0] w_word;
    logic             r_l;
    logic             w_shift_en;
    logic             w_load;
`ifdef NIBBLE_DESER_PARITY_EN
    logic             r_err;
    logic             w_perr;
`endif

    sipo_shift #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_sipo (
        .i_clk   (CLK),
        .i_rst_n (R_N),
        .i_en    (w_shift_en),
        .i_clr   (CLR),
        .i_bit   (SIN),
        .o_word  (w_word)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_shift_en  = 1'b0;
        w_load      = 1'b0;
`ifdef NIBBLE_DESER_PARITY_EN
        w_perr      = 1'b0;
`endif
        if (CLR) begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = '0;
        end else if (SVALID) begin
            unique case (r_state)
                IDLE, SHIFT: begin
                    w_shift_en = 1'b1;
                    // IDLE always holds count 0, so this also covers WIDTH=1
                    if (r_cnt == LAST) begin
`ifdef NIBBLE_DESER_PARITY_EN
                        w_state_nxt = PARITY;
                        w_cnt_nxt   = FULL;
`else
                        w_load      = 1'b1;
                        w_state_nxt = IDLE;
                        w_cnt_nxt   = '0;
`endif
                    end else begin
                        w_state_nxt = SHIFT;
                        w_cnt_nxt   = r_cnt + CW'(1);
                    end
                end
                PARITY: begin
`ifdef NIBBLE_DESER_PARITY_EN
                    w_load      = ~(^w_word ^ SIN);
                    w_perr      = ^w_word ^ SIN;
`endif
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
                default: begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge CLK or negedge R_N) begin
        if (!R_N) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_d     <= '0;
            r_l     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_l     <= w_load;
            if (w_load) begin
                r_d <= w_word;
            end
        end
    end

`ifdef NIBBLE_DESER_PARITY_EN
    always_ff @(posedge CLK or negedge R_N) begin
        if (!R_N) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_perr;
        end
    end
    assign ERR = r_err;
`else
    assign ERR = 1'b0;
`endif

    assign D    = r_d;
    assign L    = r_l;
    assign BUSY = (r_state != IDLE);

endmodule

// File: tb/tb_nibble_deserializer.sv
// Directed self-checking bench for nibble_deserializer (WIDTH=4, MSB first).
module tb_nibble_deserializer;

    logic       CLK;
    logic       R_N;
    logic       SIN;
    logic       SVALID;
    logic       CLR;
    logic [3:0] D;
    logic       L;
    logic       BUSY;
    logic       ERR;

    int n_cmp;
    int n_bad;

    nibble_deserializer #(
        .WIDTH     (4),
        .MSB_FIRST (1)
    ) dut (
        .CLK    (CLK),
        .R_N    (R_N),
        .SIN    (SIN),
        .SVALID (SVALID),
        .CLR    (CLR),
        .D      (D),
        .L      (L),
        .BUSY   (BUSY),
        .ERR    (ERR)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic bit_in(input logic b);
        SVALID = 1'b1;
        SIN    = b;
        @(posedge CLK);
        @(negedge CLK);
        SVALID = 1'b0;
    endtask

    task automatic idle(input int n);
        SVALID = 1'b0;
        repeat (n) begin
            @(posedge CLK);
            @(negedge CLK);
        end
    endtask

    initial begin
        n_cmp  = 0;
        n_bad  = 0;
        R_N    = 1'b0;
        SIN    = 1'b0;
        SVALID = 1'b0;
        CLR    = 1'b0;
        repeat (2) @(negedge CLK);
        chk("rst_D", 32'(D), 32'h0);
        chk("rst_L", 32'(L), 32'h0);
        chk("rst_BUSY", 32'(BUSY), 32'h0);
        chk("rst_ERR", 32'(ERR), 32'h0);
        R_N = 1'b1;
        idle(1);

`ifndef NIBBLE_DESER_PARITY_EN
        // basic word 1011
        bit_in(1'b1);
        chk("t1_busy1", 32'(BUSY), 32'h1);
        chk("t1_l1", 32'(L), 32'h0);
        bit_in(1'b0);
        chk("t1_busy2", 32'(BUSY), 32'h1);
        bit_in(1'b1);
        chk("t1_busy3", 32'(BUSY), 32'h1);
        chk("t1_l3", 32'(L), 32'h0);
        bit_in(1'b1);
        chk("t1_L", 32'(L), 32'h1);
        chk("t1_D", 32'(D), 32'hB);
        chk("t1_busy4", 32'(BUSY), 32'h0);
        idle(1);
        chk("t1_Loff", 32'(L), 32'h0);
        chk("t1_Dhold", 32'(D), 32'hB);

        // gapped stream 1,_,0,_,_,1,1
        bit_in(1'b1);
        idle(1);
        chk("t2_g1", 32'(L), 32'h0);
        bit_in(1'b0);
        idle(2);
        chk("t2_g2", 32'(L), 32'h0);
        chk("t2_busy", 32'(BUSY), 32'h1);
        bit_in(1'b1);
        chk("t2_b3", 32'(L), 32'h0);
        bit_in(1'b1);
        chk("t2_L", 32'(L), 32'h1);
        chk("t2_D", 32'(D), 32'hB);
        idle(1);
        chk("t2_Loff", 32'(L), 32'h0);

        // back-to-back 0101 0011
        bit_in(1'b0);
        bit_in(1'b1);
        bit_in(1'b0);
        bit_in(1'b1);
        chk("t3_L1", 32'(L), 32'h1);
        chk("t3_D1", 32'(D), 32'h5);
        bit_in(1'b0);
        chk("t3_b5_L", 32'(L), 32'h0);
        chk("t3_b5_busy", 32'(BUSY), 32'h1);
        bit_in(1'b0);
        chk("t3_b6_L", 32'(L), 32'h0);
        bit_in(1'b1);
        chk("t3_b7_L", 32'(L), 32'h0);
        bit_in(1'b1);
        chk("t3_L2", 32'(L), 32'h1);
        chk("t3_D2", 32'(D), 32'h3);
        idle(1);

        // abort partial word, CLR overrides SVALID
        bit_in(1'b1);
        bit_in(1'b0);
        CLR = 1'b1;
        bit_in(1'b1);
        CLR = 1'b0;
        chk("t4_clr_L", 32'(L), 32'h0);
        chk("t4_clr_busy", 32'(BUSY), 32'h0);
        chk("t4_clr_D", 32'(D), 32'h3);
        // CLR on the completing bit suppresses L
        bit_in(1'b1);
        bit_in(1'b1);
        bit_in(1'b1);
        CLR = 1'b1;
        bit_in(1'b1);
        CLR = 1'b0;
        chk("t4_sup_L", 32'(L), 32'h0);
        chk("t4_sup_D", 32'(D), 32'h3);
        chk("t4_sup_busy", 32'(BUSY), 32'h0);
        bit_in(1'b1);
        bit_in(1'b1);
        bit_in(1'b1);
        bit_in(1'b0);
        chk("t4_L", 32'(L), 32'h1);
        chk("t4_D", 32'(D), 32'hE);
        idle(1);

        // async reset mid-word
        bit_in(1'b1);
        bit_in(1'b1);
        bit_in(1'b1);
        #2 R_N = 1'b0;
        #1;
        chk("t5_rst_D", 32'(D), 32'h0);
        chk("t5_rst_busy", 32'(BUSY), 32'h0);
        @(negedge CLK);
        R_N = 1'b1;
        idle(2);
        chk("t5_noL", 32'(L), 32'h0);
        bit_in(1'b0);
        bit_in(1'b1);
        bit_in(1'b1);
        bit_in(1'b0);
        chk("t5_L", 32'(L), 32'h1);
        chk("t5_D", 32'(D), 32'h6);
        chk("t5_ERR", 32'(ERR), 32'h0);
        idle(1);
`else
        // good word 1011 + parity 1
        bit_in(1'b1);
        bit_in(1'b0);
        bit_in(1'b1);
        bit_in(1'b1);
        chk("p1_wait_L", 32'(L), 32'h0);
        chk("p1_wait_busy", 32'(BUSY), 32'h1);
        bit_in(1'b1);
        chk("p1_L", 32'(L), 32'h1);
        chk("p1_D", 32'(D), 32'hB);
        chk("p1_ERR", 32'(ERR), 32'h0);
        chk("p1_busy", 32'(BUSY), 32'h0);
        // bad word 0001 + parity 0
        bit_in(1'b0);
        bit_in(1'b0);
        bit_in(1'b0);
        bit_in(1'b1);
        bit_in(1'b0);
        chk("p2_ERR", 32'(ERR), 32'h1);
        chk("p2_L", 32'(L), 32'h0);
        chk("p2_D", 32'(D), 32'hB);
        idle(1);
        chk("p2_ERRoff", 32'(ERR), 32'h0);
        // good word 0110 + parity 0
        bit_in(1'b0);
        bit_in(1'b1);
        bit_in(1'b1);
        bit_in(1'b0);
        bit_in(1'b0);
        chk("p3_L", 32'(L), 32'h1);
        chk("p3_D", 32'(D), 32'h6);
        idle(1);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
